// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
//   tx_state_e  : transmit FSM state encoding
//   DATA_BITS   : data bits per character
//   parity_bit  : parity of a data byte, optionally inverted for odd parity
package uart_tx_serializer_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // Even parity is the plain XOR of the data; odd parity inverts it.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Loadable baud down-counter.
//   clk      : clock
//   rst      : asynchronous active-low reset
//   en       : count enable; bit_end is suppressed while low
//   load     : load load_val (takes priority over counting)
//   load_val : reload value, N-1 for an N-clock bit
//   bit_end  : high for the last clock of a bit (count has reached zero)
module uart_baud_counter #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_val,
  output logic                 bit_end
);

  logic [DIV_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DIV_WIDTH'(1);
    end
  end

  assign bit_end = en && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer fed from the fall-through read port of the TX FIFO.
//   clk, rst   : clock and asynchronous active-low reset
//   fifo_data  : FIFO head byte, valid while fifo_empty is low
//   fifo_empty : FIFO empty flag
//   fifo_rd_en : pop strobe, one clock per byte, only from IDLE
//   baud_div   : clocks per bit (0 and 1 both mean one clock)
//   parity_en  : append parity bit
//   parity_odd : odd (1) or even (0) parity
//   two_stop   : two stop bits (1) or one (0)
//   tx         : registered serial output, idle high
//   busy       : frame in progress
//   tx_done    : one-clock pulse in the IDLE cycle after the last stop bit
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  tx_state_e                state_q, state_d;
  logic [DATA_BITS-1:0]     shift_q, shift_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic                     stop2_q, stop2_d;
  logic [DIV_WIDTH-1:0]     reload_q, reload_d;
  logic                     par_en_q, par_en_d;
  logic                     par_bit_q, par_bit_d;
  logic                     two_stop_q, two_stop_d;
  logic                     tx_q, tx_d;
  logic                     tx_done_q, tx_done_d;

  logic                     cnt_load;
  logic [DIV_WIDTH-1:0]     cnt_load_val;
  logic                     bit_end;
  logic [DIV_WIDTH-1:0]     live_reload;

  // Divisors 0 and 1 both collapse to a one-clock bit (reload value 0).
  assign live_reload = (baud_div <= DIV_WIDTH'(1)) ? '0 : baud_div - DIV_WIDTH'(1);

  // Gated with rst so no pop can happen while reset is held.
  assign fifo_rd_en = rst && (state_q == StIdle) && !fifo_empty;

  // The frame's first bit uses the live divisor; later bits use the shadow copy.
  assign cnt_load_val = (state_q == StIdle) ? live_reload : reload_q;

  uart_baud_counter #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_counter (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q != StIdle),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .bit_end  (bit_end)
  );

  // tx_d is the line level for the state being entered, so tx is a clean register.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop2_d    = stop2_q;
    reload_d   = reload_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    tx_d       = tx_q;
    tx_done_d  = 1'b0;
    cnt_load   = bit_end;

    unique case (state_q)
      StIdle: begin
        tx_d     = 1'b1;
        cnt_load = fifo_rd_en;
        if (fifo_rd_en) begin
          shift_d    = fifo_data;
          reload_d   = live_reload;
          par_en_d   = parity_en;
          par_bit_d  = parity_bit(fifo_data, parity_odd);
          two_stop_d = two_stop;
          bit_cnt_d  = '0;
          stop2_d    = 1'b0;
          state_d    = StStart;
          tx_d       = 1'b0;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            if (par_en_q) begin
              state_d = StParity;
              tx_d    = par_bit_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_d[0];
          end
        end
      end
      StParity: begin
        tx_d = par_bit_q;
        if (bit_end) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (two_stop_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            state_d   = StIdle;
            tx_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop2_q    <= 1'b0;
      reload_q   <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop2_q    <= stop2_d;
      reload_q   <= reload_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = (state_q != StIdle);
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    fifo_data;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] baud_div;
  logic          parity_en;
  logic          parity_odd;
  logic          two_stop;
  logic          tx;
  logic          busy;
  logic          tx_done;

  // Small fall-through FIFO model.
  logic [7:0] fifo_mem [16];
  logic [3:0] wr_ptr = 4'd0;
  logic [3:0] rd_ptr = 4'd0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = fifo_mem[rd_ptr];

  always @(posedge clk) begin
    if (fifo_rd_en) rd_ptr <= rd_ptr + 4'd1;
  end

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .DIV_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Samples are taken 1 time unit after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  // Push away from the sampling point so the pop strobe is seen on the next sample.
  task automatic push_sync(input logic [7:0] b);
    @(posedge clk);
    #1;
    push(b);
    step();
  endtask

  // Waits for a pop, then checks every line bit of the frame (bits[0] first,
  // n clocks each), busy/no-pop during the frame, and the tx_done IDLE cycle.
  task automatic run_frame(input string tag, input string bits, input int n, input int exp_wait);
    int   waited;
    int   bad;
    logic exp_b;
    logic got;
    waited = 0;
    while (!fifo_rd_en && waited < 200) begin
      step();
      waited++;
    end
    if (!fifo_rd_en) begin
      check_eq({tag, "_pop_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (exp_wait >= 0) check_eq({tag, "_gap"}, waited, exp_wait);
    bad = 0;
    for (int b = 0; b < bits.len(); b++) begin
      exp_b = (bits[b] == "1");
      got   = exp_b;
      for (int c = 0; c < n; c++) begin
        step();
        if (tx !== exp_b) got = tx;
        if (busy !== 1'b1 || tx_done !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
      end
      check_eq($sformatf("%s_bit%0d", tag, b), got, exp_b);
    end
    check_eq({tag, "_busy"}, bad, 0);
    step();
    check_eq({tag, "_done"}, {tx_done, busy, tx}, 3'b101);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd_seen;
    rst        = 1'b1;
    baud_div   = DW'(4);
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
    #2 rst = 1'b0;
    step();
    step();
    check_eq("rst_out", {tx, busy, tx_done, fifo_rd_en}, 4'b1000);
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    step();
    check_eq("idle_out", {tx, busy, tx_done, fifo_rd_en}, 4'b1000);

    // 0xA5, N=4, no parity, one stop.
    push_sync(8'hA5);
    run_frame("a5", "0101001011", 4, 0);

    // 0x07, N=2, even then odd parity.
    baud_div  = DW'(2);
    parity_en = 1'b1;
    push_sync(8'h07);
    run_frame("par_even", "01110000011", 2, 0);
    parity_odd = 1'b1;
    push_sync(8'h07);
    run_frame("par_odd", "01110000001", 2, 0);
    parity_en  = 1'b0;
    parity_odd = 1'b0;

    // Two stop bits, N=3: 0x3C.
    baud_div = DW'(3);
    two_stop = 1'b1;
    push_sync(8'h3C);
    run_frame("stop2", "00011110011", 3, 0);
    two_stop = 1'b0;

    // Back-to-back, N=2.
    baud_div = DW'(2);
    @(posedge clk);
    #1;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    step();
    run_frame("b2b0", "0100010001", 2, 0);
    run_frame("b2b1", "0010001001", 2, 0);
    run_frame("b2b2", "0110011001", 2, 0);

    // Divisor changed mid-frame: first frame stays at 4, second uses 8.
    baud_div = DW'(4);
    @(posedge clk);
    #1;
    push(8'h5A);
    push(8'hC3);
    step();
    fork
      run_frame("cfg0", "0010110101", 4, 0);
      begin
        repeat (12) step();
        baud_div = DW'(8);
      end
    join
    run_frame("cfg1", "0110000111", 8, 0);

    // Divisor 0 means one clock per bit.
    baud_div = DW'(0);
    push_sync(8'h81);
    run_frame("div0", "0100000011", 1, 0);

    // Reset during data bit 3 of 0x96, with 0x3F still queued.
    baud_div = DW'(2);
    @(posedge clk);
    #1;
    push(8'h96);
    push(8'h3F);
    step();
    check_eq("rst_pop", fifo_rd_en, 1'b1);
    repeat (9) step();
    check_eq("rst_pre", {busy, tx}, 2'b10);
    rst = 1'b0;
    #1;
    check_eq("rst_async", {tx, busy, tx_done, fifo_rd_en}, 4'b1000);
    rd_seen = 0;
    repeat (5) begin
      step();
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) rd_seen++;
    end
    check_eq("rst_hold", rd_seen, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    run_frame("post_rst", "0111111001", 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
